// File: rtl/relu_maxpool_2x2.sv
// Rectifies a raster stream of convolution results and max-pools it with a 2x2 window.
// A horizontal pair is reduced in a hold register; pair maxima of even rows wait in a half-row line buffer.
module relu_maxpool_2x2 #(
  parameter int IN_W = 28,
  parameter int IN_H = 28,
  parameter int DW   = 16
) (
  input  logic                 iCLK,
  input  logic                 iRSTn,
  input  logic                 iValid,
  input  logic signed [DW-1:0] iY,
  output logic signed [DW-1:0] oP,
  output logic                 oValid,
  output logic                 oFrameDone
);

  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int BW = IN_W / 2;
  localparam int AW = (BW > 1) ? $clog2(BW) : 1;

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic signed [DW-1:0] p_d;
  logic                 valid_d, frame_done_d;

  logic signed [DW-1:0] line_mem [BW];
  logic signed [DW-1:0] line_rd_q;

  logic signed [DW-1:0] r, pm, pool;
  logic [AW-1:0]        idx;
  logic                 col_odd, row_odd, col_last, row_last;

  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign col_last = (col_q == CW'(IN_W - 1));
  assign row_last = (row_q == RW'(IN_H - 1));
  assign idx      = AW'(col_q >> 1);

  // Operands are non-negative after rectification, so signed compares need no widening.
  assign r    = iY[DW-1] ? '0 : iY;
  assign pm   = (r > hold_q) ? r : hold_q;
  assign pool = (line_rd_q > pm) ? line_rd_q : pm;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    p_d          = oP;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    if (iValid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_odd) begin
        hold_d = r;
      end
      if (col_odd && row_odd) begin
        valid_d      = 1'b1;
        frame_done_d = col_last && row_last;
        p_d          = pool;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      oP         <= '0;
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      oP         <= p_d;
      oValid     <= valid_d;
      oFrameDone <= frame_done_d;
    end
  end

  // The buffer entry is fetched on the even column so it is ready, registered, for the odd column.
  always_ff @(posedge iCLK) begin
    if (iValid && col_odd && !row_odd) begin
      line_mem[idx] <= pm;
    end
    if (iValid && !col_odd) begin
      line_rd_q <= line_mem[idx];
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Randomized and directed stimulus for relu_maxpool_2x2, checked against a window-level pooling model.
module tb_relu_maxpool_2x2;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 iv = 1'b0;
  logic signed [DW-1:0] iy = '0;
  logic signed [DW-1:0] op;
  logic                 ov, fd;

  logic                 iv4 = 1'b0;
  logic signed [DW-1:0] iy4 = '0;
  logic signed [DW-1:0] op4;
  logic                 ov4, fd4;

  always #5 clk = ~clk;

  relu_maxpool_2x2 #(.IN_W(W), .IN_H(H), .DW(DW)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iValid(iv), .iY(iy),
    .oP(op), .oValid(ov), .oFrameDone(fd)
  );

  relu_maxpool_2x2 #(.IN_W(4), .IN_H(4), .DW(DW)) dut4 (
    .iCLK(clk), .iRSTn(rst_n), .iValid(iv4), .iY(iy4),
    .oP(op4), .oValid(ov4), .oFrameDone(fd4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int     val;
    bit     last;
    longint cyc;
  } exp_t;

  int     fr [H][W];
  exp_t   exp_q [$];
  longint cyc = 0;
  int     n_out = 0;
  int     n_fd = 0;
  int     last_p = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Maximum of the rectified 2x2 window at pooled coordinates (pr, pc).
  function automatic int pool_at(input int pr, input int pc);
    int m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu(fr[2*pr+dr][2*pc+dc]) > m) m = relu(fr[2*pr+dr][2*pc+dc]);
    return m;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = r * W + c;
  endtask

  task automatic fill_neg();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = (((r * W + c) % 2) == 0) ? -32768 : -1;
  endtask

  task automatic fill_rand();
    logic [DW-1:0] t;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        t = DW'($urandom);
        fr[r][c] = int'($signed(t));
      end
  endtask

  // mode 0: contiguous, 1: valid every third cycle, 2: random gaps
  task automatic send_frame(input int mode, input int nsamp);
    int r, c, gaps;
    for (int k = 0; k < nsamp; k++) begin
      r = k / W;
      c = k % W;
      gaps = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
      repeat (gaps) begin
        @(posedge clk);
        #1;
      end
      iv = 1'b1;
      iy = DW'(fr[r][c]);
      if ((r % 2 == 1) && (c % 2 == 1))
        exp_q.push_back('{pool_at(r / 2, c / 2), (r == H - 1) && (c == W - 1), cyc + 1});
      @(posedge clk);
      #1;
      iv = 1'b0;
    end
  endtask

  task automatic run_test(input string name, input int mode, input int frames);
    n_out = 0;
    n_fd  = 0;
    repeat (frames) send_frame(mode, W * H);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_outputs"}, n_out, frames * (W / 2) * (H / 2));
    check({name, "_frame_done"}, n_fd, frames);
    check({name, "_pending"}, exp_q.size(), 0);
    $display("test %s: %0d outputs, %0d frame pulses", name, n_out, n_fd);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid", ov, 0);
      last_p = 0;
    end else begin
      if (fd) n_fd++;
      if (ov) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pool_val", op, e.val);
          check("latency", cyc, e.cyc);
          check("frame_done", fd, e.last);
        end
        last_p = op;
      end else begin
        check("hold_p", op, last_p);
        check("fd_idle", fd, 0);
      end
    end
  end

  int q4 [$];
  int n_fd4 = 0;

  always @(negedge clk) begin
    if (rst_n && ov4) begin
      q4.push_back(int'(op4));
      if (fd4) n_fd4++;
    end
  end

  initial begin
    int v4 [16] = '{5, -3, 1, 2, 7, 100, 2, 50, -8, -8, 0, 0, -8, 9, 0, -1};
    wait (rst_n === 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      iv4 = 1'b1;
      iy4 = DW'(v4[k]);
      @(posedge clk);
      #1;
    end
    iv4 = 1'b0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp4 [4] = '{100, 50, 9, 0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_oP", op, 0);
    check("reset_oValid", ov, 0);
    check("reset_oFrameDone", fd, 0);
    rst_n = 1'b1;

    fill_ramp();
    run_test("ramp", 0, 1);
    fill_neg();
    run_test("negative", 0, 1);
    fill_ramp();
    run_test("throttled", 1, 1);
    run_test("back_to_back", 0, 2);
    fill_rand();
    run_test("random_gaps", 2, 1);
    fill_rand();
    run_test("random_dense", 0, 1);

    fill_ramp();
    send_frame(0, 301);
    @(posedge clk);
    #1;
    check("pre_reset_pending", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_oP", op, 0);
    check("async_rst_oValid", ov, 0);
    check("async_rst_oFrameDone", fd, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_test("after_reset", 0, 1);

    check("win4_count", q4.size(), 4);
    for (int i = 0; i < 4; i++)
      check("win4_val", (i < q4.size()) ? q4[i] : -1, exp4[i]);
    check("win4_frame_done", n_fd4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
